// File: rtl/arm_pipe_pkg.sv
// Shared ARMv8 pipeline definitions: datapath widths, the bubble word,
// the IF stage state encodings and the IF/ID register payload.
package arm_pipe_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;

   localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

   // S_REQ : fetch request outstanding at pc
   // S_HOLD: skid holds a word that the stalled IF/ID could not take
   // S_DROP: a fetch issued before a redirect is still outstanding
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } if_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
      logic [ADDR_W-1:0]  pc_link;
      logic               vld;
   } ifid_t;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register. flush_i writes a bubble and wins over load_i;
// with neither asserted the register holds its contents.
module if_id_reg
   import arm_pipe_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic  clock,
   input  logic  reset,
   input  logic  load_i,
   input  logic  flush_i,
   input  ifid_t d_i,
   output ifid_t q_o
);

   ifid_t bubble;
   ifid_t ifid_q;

   assign bubble = '{instr: NOP_WORD, pc: '0, pc_link: '0, vld: 1'b0};
   assign q_o    = ifid_q;

   // Bubble on reset/flush, capture on load, otherwise hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)        ifid_q <= bubble;
      else if (flush_i) ifid_q <= bubble;
      else if (load_i)  ifid_q <= d_i;
   end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction-memory handshake, 1-entry stall skid and
// branch redirect/squash, feeding the IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds saturating performance counters.
module instruction_fetch
   import arm_pipe_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  PC_RESET = 64'h0,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall_cycles,
   output logic [31:0]        perf_flushes,
`endif
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  PC_out,
   output logic [ADDR_W-1:0]  PC_branch_link_out,
   output logic               if_valid
);

   if_state_e          state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  drop_addr_q;
   logic [ADDR_W-1:0]  skid_pc_q;
   logic [INSTR_W-1:0] skid_instr_q;

   logic  ifid_ld, ifid_fl;
   ifid_t ifid_d, ifid_q;

   // A stale fetch keeps its original address until the memory answers it.
   assign imem_req  = !reset && (state_q != S_HOLD);
   assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

   // IF/ID control: redirect squashes; otherwise take the fresh word or the
   // skid, or insert a bubble when nothing usable arrived and decode is free.
   always_comb begin
      ifid_ld = 1'b0;
      ifid_fl = 1'b0;
      ifid_d  = '{instr: skid_instr_q, pc: skid_pc_q,
                  pc_link: skid_pc_q + 64'd4, vld: 1'b1};
      if (branch_taken) begin
         ifid_fl = 1'b1;
      end else begin
         case (state_q)
            S_REQ: begin
               if (!stall && imem_valid) begin
                  ifid_ld = 1'b1;
                  ifid_d  = '{instr: imem_rdata, pc: pc_q,
                              pc_link: pc_q + 64'd4, vld: 1'b1};
               end else if (!stall) begin
                  ifid_fl = 1'b1;
               end
            end
            S_HOLD:  ifid_ld = !stall;
            default: ifid_fl = !stall;
         endcase
      end
   end

   // Fetch FSM with PC, skid and stale-request address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_REQ;
         pc_q         <= PC_RESET;
         drop_addr_q  <= '0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_WORD;
      end else if (branch_taken) begin
         pc_q         <= branch_target & ~64'h3;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_WORD;
         if (state_q != S_HOLD && !imem_valid) begin
            state_q <= S_DROP;
            if (state_q == S_REQ) drop_addr_q <= pc_q;
         end else begin
            state_q <= S_REQ;
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_valid) begin
                  pc_q <= pc_q + 64'd4;
                  if (stall) begin
                     skid_pc_q    <= pc_q;
                     skid_instr_q <= imem_rdata;
                     state_q      <= S_HOLD;
                  end
               end
            end
            S_HOLD:  if (!stall) state_q <= S_REQ;
            S_DROP:  if (imem_valid) state_q <= S_REQ;
            default: state_q <= S_REQ;
         endcase
      end
   end

   if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
      .clock   (clock),
      .reset   (reset),
      .load_i  (ifid_ld),
      .flush_i (ifid_fl),
      .d_i     (ifid_d),
      .q_o     (ifid_q)
   );

   assign instruction        = ifid_q.instr;
   assign PC_out             = ifid_q.pc;
   assign PC_branch_link_out = ifid_q.pc_link;
   assign if_valid           = ifid_q.vld;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetched_q, stall_cyc_q, flushes_q;

   // Saturating event counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetched_q   <= '0;
         stall_cyc_q <= '0;
         flushes_q   <= '0;
      end else begin
         if (ifid_ld && !ifid_fl && ifid_d.vld && fetched_q != '1)
            fetched_q <= fetched_q + 32'd1;
         if (stall && stall_cyc_q != '1)
            stall_cyc_q <= stall_cyc_q + 32'd1;
         if (branch_taken && flushes_q != '1)
            flushes_q <= flushes_q + 32'd1;
      end
   end

   assign perf_fetched      = fetched_q;
   assign perf_stall_cycles = stall_cyc_q;
   assign perf_flushes      = flushes_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a ROM model returning addr>>2 with
// programmable latency, directed scenarios pushing the expected IF/ID loads,
// and a monitor popping/comparing on every real IF/ID load.
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = '0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [63:0] PC_out;
   logic [63:0] PC_branch_link_out;
   logic        if_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall_cycles, perf_flushes;
`endif

   int nchk  = 0;
   int nfail = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   instruction_fetch #(.PC_RESET(64'h0), .NOP_WORD(32'h0)) dut (
      .clock              (clock),
      .reset              (reset),
      .stall              (stall),
      .branch_taken       (branch_taken),
      .branch_target      (branch_target),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_valid         (imem_valid),
      .imem_rdata         (imem_rdata),
`ifdef IF_PERF_CNT_EN
      .perf_fetched       (perf_fetched),
      .perf_stall_cycles  (perf_stall_cycles),
      .perf_flushes       (perf_flushes),
`endif
      .instruction        (instruction),
      .PC_out             (PC_out),
      .PC_branch_link_out (PC_branch_link_out),
      .if_valid           (if_valid)
   );

   // ROM model: answers lat cycles after the request starts.
   int lat = 0;
   int cnt;
   assign imem_valid = imem_req && (cnt == lat);
   assign imem_rdata = imem_addr[33:2];
   always @(posedge clock or posedge reset) begin
      if (reset) cnt <= 0;
      else       cnt <= (imem_req && !imem_valid) ? cnt + 1 : 0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      nchk++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push(input logic [63:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = pc[33:2];
      exp_q.push_back(e);
   endtask

   task automatic nedge();
      @(negedge clock);
      #1;
   endtask

   // Monitor: after any non-stalled, non-reset edge a valid IF/ID is a new load.
   logic        stall_e, rst_e, pend_e;
   logic [63:0] addr_e;
   always @(posedge clock) begin
      stall_e <= stall;
      rst_e   <= reset;
      pend_e  <= !reset && imem_req && !imem_valid;
      addr_e  <= imem_addr;
   end

   always @(negedge clock) begin
      if (!reset && !rst_e && !stall_e && if_valid) begin
         if (exp_q.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_load actual PC_out=%h required none", PC_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ifid_pc", PC_out, e.pc);
            chk("ifid_instr", {32'h0, instruction}, {32'h0, e.instr});
            chk("ifid_link", PC_branch_link_out, e.pc + 64'd4);
         end
      end
      if (!reset && pend_e && imem_req) chk("addr_hold", imem_addr, addr_e);
   end

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req"}, {63'h0, imem_req}, 64'h0);
      chk({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
      chk({tag, "_instr"}, {32'h0, instruction}, 64'h0);
      chk({tag, "_pc"}, PC_out, 64'h0);
      chk({tag, "_link"}, PC_branch_link_out, 64'h0);
   endtask

   task automatic do_reset(input int l);
      nedge();
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; lat = l;
      nedge();
      chk_reset_outs("rst");
      reset = 1'b0;
      #1;
      chk("rel_req", {63'h0, imem_req}, 64'h1);
      chk("rel_addr", imem_addr, 64'h0);
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_drained"}, 64'(exp_q.size()), 64'h0);
      exp_q.delete();
   endtask

   initial begin
      // Zero-wait streaming: one instruction per cycle.
      do_reset(0);
      for (int i = 0; i < 5; i++) push(64'(4 * i));
      for (int i = 0; i < 5; i++) begin
         nedge();
         chk("zw_valid", {63'h0, if_valid}, 64'h1);
      end
      stall = 1'b1;
      nedge();
      chk_drained("zw");

      // Two-cycle memory: two bubbles between instructions.
      do_reset(2);
      push(64'h0); push(64'h4);
      begin
         logic [5:0] pat;
         pat = 6'b100100;
         for (int i = 0; i < 6; i++) begin
            nedge();
            chk("lat2_valid", {63'h0, if_valid}, {63'h0, pat[i]});
         end
      end
      stall = 1'b1;
      nedge();
      chk_drained("lat2");

      // Stall while word @0x8 returns: skid, hold, release.
      do_reset(0);
      push(64'h0); push(64'h4); push(64'h8); push(64'hC);
      nedge();
      nedge();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nedge();
         chk("stl_hold_pc", PC_out, 64'h4);
         chk("stl_hold_vld", {63'h0, if_valid}, 64'h1);
         chk("stl_req", {63'h0, imem_req}, 64'h0);
      end
      stall = 1'b0;
      nedge();
      chk("stl_next_addr", imem_addr, 64'hC);
      chk("stl_next_req", {63'h0, imem_req}, 64'h1);
      nedge();
      stall = 1'b1;
      nedge();
      chk_drained("stl");

      // Redirect to 0x103 with a fetch outstanding.
      do_reset(2);
      push(64'h100);
      nedge();
      branch_taken = 1'b1; branch_target = 64'h103;
      nedge();
      branch_taken = 1'b0;
      chk("br_bubble", {63'h0, if_valid}, 64'h0);
      chk("br_stale_addr", imem_addr, 64'h0);
      chk("br_stale_req", {63'h0, imem_req}, 64'h1);
      nedge();
      chk("br_new_addr", imem_addr, 64'h100);
      chk("br_bubble2", {63'h0, if_valid}, 64'h0);
      nedge(); nedge(); nedge();
      stall = 1'b1;
      nedge();
      chk_drained("br");

      // Redirect and stall together while the skid is full.
      do_reset(0);
      push(64'h0); push(64'h200);
      nedge();
      stall = 1'b1;
      nedge();
      chk("hb_req", {63'h0, imem_req}, 64'h0);
      chk("hb_hold_pc", PC_out, 64'h0);
      branch_taken = 1'b1; branch_target = 64'h200;
      nedge();
      chk("hb_bubble", {63'h0, if_valid}, 64'h0);
      chk("hb_addr", imem_addr, 64'h200);
      chk("hb_req2", {63'h0, imem_req}, 64'h1);
      branch_taken = 1'b0; stall = 1'b0;
      nedge();
      stall = 1'b1;
      nedge();
      chk_drained("hb");

      // Reset asserted mid-request.
      do_reset(0);
      push(64'h0); push(64'h4);
      nedge();
      nedge();
      reset = 1'b1;
      #1;
      chk_reset_outs("mid");
      nedge();
      nedge();
      reset = 1'b0;
      #1;
      chk("mid_rel_req", {63'h0, imem_req}, 64'h1);
      chk("mid_rel_addr", imem_addr, 64'h0);
      push(64'h0);
      nedge();
      stall = 1'b1;
      nedge();
      chk_drained("mid");

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
